// File: rtl/platform_field.sv
// platform_field: bookkeeping for NUM_PLATS platforms. On each frame_clk rise the
// platforms scroll down by a clamped amount, one platform per Clk cycle. A platform
// that falls off the bottom is recycled to the top at an LFSR-random X. Also
// provides a registered landing query for the doodle.
//
// Ports:
//   Clk, Reset       system clock, asynchronous active-high reset
//   frame_clk        vsync, asynchronous to Clk (synchronised here)
//   scroll_dy        downward scroll for the next frame (clamped to SPACING)
//   doodle_x/w/bottom, falling   doodle geometry for landing detection
//   plat_x_flat, plat_y_flat     platform i at [i*COORD_W +: COORD_W]
//   busy, frame_done             walk in progress / one-cycle walk-complete pulse
//   land_hit, land_idx, land_y   landing result, 1-cycle latency, lowest index wins
//   recycle_count                saturating count of recycled platforms
//   overrun                      sticky: a frame tick arrived while busy
module platform_field #(
  parameter int          NUM_PLATS = 15,
  parameter int          COORD_W   = 10,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          PLAT_W    = 40,
  parameter int          PLAT_H    = 8,
  parameter int          SPACING   = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic [COORD_W-1:0]             scroll_dy,
  input  logic [COORD_W-1:0]             doodle_x,
  input  logic [COORD_W-1:0]             doodle_w,
  input  logic [COORD_W-1:0]             doodle_bottom,
  input  logic                           falling,
  output logic [NUM_PLATS*COORD_W-1:0]   plat_x_flat,
  output logic [NUM_PLATS*COORD_W-1:0]   plat_y_flat,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           land_hit,
  output logic [4:0]                     land_idx,
  output logic [COORD_W-1:0]             land_y,
  output logic [15:0]                    recycle_count,
  output logic                           overrun
);

  localparam int IDX_W  = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
  localparam int X_SPAN = SCREEN_W - PLAT_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   walk_idx;
  logic [COORD_W-1:0] dy;
  logic [15:0]        lfsr;
  logic [2:0]         fsync;
  logic               tick;

  logic [COORD_W-1:0] plat_x [NUM_PLATS];
  logic [COORD_W-1:0] plat_y [NUM_PLATS];

  // One Fibonacci step of x^16+x^14+x^13+x^11+1 (right-shifting form).
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Fold an LFSR sample into [0, X_SPAN); one subtraction suffices because
  // 2^COORD_W <= 2*X_SPAN.
  function automatic logic [COORD_W-1:0] wrap_x(input logic [COORD_W-1:0] r);
    wrap_x = (r >= COORD_W'(X_SPAN)) ? r - COORD_W'(X_SPAN) : r;
  endfunction

  // Two synchroniser flops (fsync[0], fsync[1]) plus a history flop for edge detect.
  assign tick = fsync[1] & ~fsync[2];

  logic [COORD_W:0] ny;
  logic             wrap;
  assign ny   = {1'b0, plat_y[walk_idx]} + {1'b0, dy};
  assign wrap = ny >= (COORD_W+1)'(SCREEN_H);

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      walk_idx      <= '0;
      dy            <= '0;
      lfsr          <= LFSR_SEED;
      fsync         <= '0;
      recycle_count <= '0;
      overrun       <= 1'b0;
      for (int i = 0; i < NUM_PLATS; i++) begin
        plat_y[i] <= COORD_W'(i * SPACING);
        plat_x[i] <= COORD_W'((i * 73) % X_SPAN);
      end
    end else begin
      fsync <= {fsync[1:0], frame_clk};
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            dy       <= (scroll_dy > COORD_W'(SPACING)) ? COORD_W'(SPACING) : scroll_dy;
            walk_idx <= '0;
            state    <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (wrap) begin
            plat_y[walk_idx] <= COORD_W'(ny - (COORD_W+1)'(SCREEN_H));
            plat_x[walk_idx] <= wrap_x(lfsr[COORD_W-1:0]);
            lfsr             <= lfsr_next(lfsr);
            if (recycle_count != 16'hFFFF) recycle_count <= recycle_count + 16'd1;
          end else begin
            plat_y[walk_idx] <= ny[COORD_W-1:0];
          end
          if (walk_idx == IDX_W'(NUM_PLATS - 1)) state <= ST_DONE;
          else walk_idx <= walk_idx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Landing search: scan high-to-low so the lowest matching index is left in hit_sel.
  logic             hit_any;
  logic [IDX_W-1:0] hit_sel;
  logic [COORD_W:0] feet_right;
  assign feet_right = {1'b0, doodle_x} + {1'b0, doodle_w};

  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = NUM_PLATS - 1; i >= 0; i--) begin
      if (falling &&
          (doodle_bottom >= plat_y[i]) &&
          ({1'b0, doodle_bottom} < {1'b0, plat_y[i]} + (COORD_W+1)'(PLAT_H)) &&
          (feet_right > {1'b0, plat_x[i]}) &&
          ({1'b0, doodle_x} < {1'b0, plat_x[i]} + (COORD_W+1)'(PLAT_W))) begin
        hit_any = 1'b1;
        hit_sel = IDX_W'(i);
      end
    end
  end

  // Landing register: a tick in IDLE starts a walk next cycle, so it suppresses
  // the result too; land_hit is therefore never high while busy.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      land_hit <= 1'b0;
      land_idx <= '0;
      land_y   <= '0;
    end else if (state == ST_IDLE && !tick && hit_any) begin
      land_hit <= 1'b1;
      land_idx <= 5'(hit_sel);
      land_y   <= plat_y[hit_sel];
    end else begin
      land_hit <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_PLATS; g++) begin : g_flat
    assign plat_x_flat[g*COORD_W +: COORD_W] = plat_x[g];
    assign plat_y_flat[g*COORD_W +: COORD_W] = plat_y[g];
  end

endmodule

// File: tb/tb_platform_field.sv
module tb_platform_field;

  localparam int NP = 15;
  localparam int CW = 10;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_clk = 1'b0;
  logic [CW-1:0] scroll_dy = '0;
  logic [CW-1:0] doodle_x = '0;
  logic [CW-1:0] doodle_w = '0;
  logic [CW-1:0] doodle_bottom = '0;
  logic          falling = 1'b0;
  logic [NP*CW-1:0] plat_x_flat, plat_y_flat;
  logic          busy, frame_done, land_hit, overrun;
  logic [4:0]    land_idx;
  logic [CW-1:0] land_y;
  logic [15:0]   recycle_count;

  platform_field dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .scroll_dy(scroll_dy),
    .doodle_x(doodle_x), .doodle_w(doodle_w), .doodle_bottom(doodle_bottom),
    .falling(falling), .plat_x_flat(plat_x_flat), .plat_y_flat(plat_y_flat),
    .busy(busy), .frame_done(frame_done), .land_hit(land_hit), .land_idx(land_idx),
    .land_y(land_y), .recycle_count(recycle_count), .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of platform state.
  int          m_x [NP];
  int          m_y [NP];
  logic [15:0] m_lfsr;
  int          m_rc;

  function automatic int get_x(input int i);
    return int'(plat_x_flat[i*CW +: CW]);
  endfunction
  function automatic int get_y(input int i);
    return int'(plat_y_flat[i*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_y[i] = i * 32;
      m_x[i] = (i * 73) % 600;
    end
    m_lfsr = 16'hACE1;
    m_rc   = 0;
  endtask

  task automatic model_frame(input int sdy);
    int d, ny, r;
    logic fb;
    d = (sdy > 32) ? 32 : sdy;
    for (int i = 0; i < NP; i++) begin
      ny = m_y[i] + d;
      if (ny >= 480) begin
        m_y[i] = ny - 480;
        r = int'(m_lfsr & 16'h03FF);
        m_x[i] = (r >= 600) ? r - 600 : r;
        fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = {fb, m_lfsr[15:1]};
        if (m_rc < 65535) m_rc++;
      end else begin
        m_y[i] = ny;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_y%0d", tag, i), get_y(i), m_y[i]);
      check($sformatf("%s_x%0d", tag, i), get_x(i), m_x[i]);
    end
    check({tag, "_rc"}, recycle_count, m_rc);
  endtask

  task automatic do_reset();
    frame_clk = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
  endtask

  // One frame: raise frame_clk and count busy cycles and done pulses in a bounded window.
  task automatic run_frame(input int sdy, output int bcnt, output int dcnt);
    scroll_dy = CW'(sdy);
    bcnt = 0;
    dcnt = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (busy) bcnt++;
      if (frame_done) dcnt++;
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    model_frame(sdy);
  endtask

  int bc, dc, waited;
  logic all_mult;

  initial begin
    // 1. reset defaults
    do_reset();
    check("rst_y14", get_y(14), 448);
    check("rst_y0", get_y(0), 0);
    check("rst_x3", get_x(3), 219);
    check("rst_x9", get_x(9), 57);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_rc", recycle_count, 0);
    check("rst_ovr", overrun, 0);
    check("rst_land", land_hit, 0);

    // 2. one frame, dy=10
    run_frame(10, bc, dc);
    check("f10_busy_cycles", bc, 16);
    check("f10_done_pulses", dc, 1);
    check("f10_y0", get_y(0), 10);
    check("f10_y14", get_y(14), 458);
    check("f10_rc", recycle_count, 0);
    compare_all("f10");
    // LFSR untouched: the next recycle still draws from the seed (0xACE1 & 0x3FF = 225)
    run_frame(32, bc, dc);
    check("f10_then32_x14", get_x(14), 225);

    // 3. dy=32 from reset, then fifteen frames
    do_reset();
    run_frame(32, bc, dc);
    check("f32_y14", get_y(14), 0);
    check("f32_x14", get_x(14), 225);
    check("f32_x14_range", get_x(14) < 600, 1);
    check("f32_rc", recycle_count, 1);
    for (int f = 1; f < 15; f++) run_frame(32, bc, dc);
    check("f32x15_rc", recycle_count, 15);
    all_mult = 1'b1;
    for (int i = 0; i < NP; i++) if (get_y(i) % 32 != 0) all_mult = 1'b0;
    check("f32x15_mult32", all_mult, 1);
    compare_all("f32x15");

    // 4. clamp: dy=50 behaves as 32
    do_reset();
    run_frame(50, bc, dc);
    check("clamp_y0", get_y(0), 32);
    check("clamp_y14", get_y(14), 0);
    check("clamp_rc", recycle_count, 1);

    // 5. landing detection from reset positions
    do_reset();
    doodle_x = 10'd230; doodle_w = 10'd20; doodle_bottom = 10'd100; falling = 1'b1;
    @(negedge Clk);
    check("land_hit", land_hit, 1);
    check("land_idx", land_idx, 3);
    check("land_y", land_y, 96);
    falling = 1'b0;
    @(negedge Clk);
    check("land_notfalling", land_hit, 0);
    check("land_idx_hold", land_idx, 3);
    falling = 1'b1;
    doodle_x = 10'd260;
    @(negedge Clk);
    check("land_right_miss", land_hit, 0);
    doodle_x = 10'd230; doodle_bottom = 10'd104;
    @(negedge Clk);
    check("land_below_miss", land_hit, 0);
    falling = 1'b0;

    // 6a. second tick during a walk sets overrun, is dropped
    do_reset();
    scroll_dy = 10'd10;
    @(negedge Clk);
    frame_clk = 1'b1;
    waited = 0;
    while (!busy && waited < 10) begin @(negedge Clk); waited++; end
    check("ovr_walk_started", busy, 1);
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b1;
    dc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (frame_done) dc++;
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    model_frame(10);
    check("ovr_flag", overrun, 1);
    check("ovr_done_pulses", dc, 1);
    check("ovr_y0", get_y(0), 10);
    check("ovr_y14", get_y(14), 458);
    check("ovr_busy_after", busy, 0);

    // 6b. reset in the middle of a walk
    @(negedge Clk);
    frame_clk = 1'b1;
    waited = 0;
    while (!busy && waited < 10) begin @(negedge Clk); waited++; end
    repeat (6) @(negedge Clk);
    check("mid_busy", busy, 1);
    Reset = 1'b1;
    frame_clk = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", frame_done, 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (frame_done) dc++;
    end
    check("mid_no_done", dc, 0);
    check("mid_ovr_clear", overrun, 0);
    compare_all("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
